// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU: 4-bit operation codes and decode helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_MFLO  = 4'b0011;
    localparam logic [3:0] ALU_SRL   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SRA   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_MFHI  = 4'b1010;
    localparam logic [3:0] ALU_NOR   = 4'b1011;
    localparam logic [3:0] ALU_MULT  = 4'b1100;
    localparam logic [3:0] ALU_MULTU = 4'b1101;
    localparam logic [3:0] ALU_DIV   = 4'b1110;
    localparam logic [3:0] ALU_DIVU  = 4'b1111;

    // The four multi-cycle ops occupy the top quarter of the code space.
    function automatic logic is_muldiv(input logic [3:0] c);
        return (c[3:2] == 2'b11);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiplier (shift-add) and restoring divider writing HI/LO.
// Latency: WIDTH+1 edges from accepted start to done (one bit per cycle after the latch edge).
// Backpressure: start is ignored while busy=1; no queueing.
// Ports: clk, rst (sync, active-high); start, op[1:0] (00 mult, 01 multu, 10 div, 11 divu), A, B;
//        busy, done (1-cycle pulse), fin/fin_lo (final-iteration flag and the LO value being written), hi, lo.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             fin,
    output logic [WIDTH-1:0] fin_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt;
    logic             is_div_q;
    logic             neg_q;      // negate product / quotient at the end
    logic             rneg_q;     // negate remainder (dividend was negative)
    logic             dz_q;       // divide by zero
    logic [WIDTH-1:0] a_q;        // original A, returned as HI on divide by zero
    logic [WIDTH-1:0] m_q;        // multiplicand or divisor magnitude
    logic [WIDTH-1:0] w_hi;       // product high half / partial remainder
    logic [WIDTH-1:0] w_lo;       // multiplier being consumed / dividend shifting into quotient

    logic             sgn_a, sgn_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   sum, sh;
    logic             ge;
    logic [WIDTH-1:0] nx_hi, nx_lo, fin_hi;
    logic [2*WIDTH-1:0] prod;

    // Signed ops (op[0]==0) work on magnitudes; signs are restored at the end.
    always_comb begin
        sgn_a = ~op[0] & A[WIDTH-1];
        sgn_b = ~op[0] & B[WIDTH-1];
        mag_a = sgn_a ? -A : A;
        mag_b = sgn_b ? -B : B;
    end

    always_comb begin
        // Multiply step: conditional add into the high half, then shift the pair right.
        sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, m_q} : '0);
        // Divide step: shift next dividend bit into the remainder, subtract if it fits.
        sh  = {w_hi, w_lo[WIDTH-1]};
        ge  = (sh >= {1'b0, m_q});
        if (is_div_q) begin
            nx_hi = ge ? WIDTH'(sh - {1'b0, m_q}) : sh[WIDTH-1:0];
            nx_lo = {w_lo[WIDTH-2:0], ge};
        end else begin
            nx_hi = sum[WIDTH:1];
            nx_lo = {sum[0], w_lo[WIDTH-1:1]};
        end

        prod = neg_q ? -{nx_hi, nx_lo} : {nx_hi, nx_lo};
        if (!is_div_q) begin
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end else if (dz_q) begin
            fin_hi = a_q;
            fin_lo = '1;
        end else begin
            fin_hi = rneg_q ? -nx_hi : nx_hi;
            fin_lo = neg_q  ? -nx_lo : nx_lo;
        end
    end

    assign fin = busy && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            a_q      <= '0;
            m_q      <= '0;
            w_hi     <= '0;
            w_lo     <= '0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                w_hi <= nx_hi;
                w_lo <= nx_lo;
                cnt  <= cnt + 1'b1;
                if (fin) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    hi   <= fin_hi;
                    lo   <= fin_lo;
                    cnt  <= '0;
                end
            end else if (start) begin
                busy     <= 1'b1;
                cnt      <= '0;
                is_div_q <= op[1];
                neg_q    <= sgn_a ^ sgn_b;
                rneg_q   <= sgn_a;
                dz_q     <= (B == '0);
                a_q      <= A;
                m_q      <= mag_b;
                w_hi     <= '0;
                w_lo     <= mag_a;
            end
        end
    end

endmodule

// File: rtl/mdu_alu.sv
// EX-stage ALU: single-cycle logic/arith/shift/compare ops plus iterative mult/div into HI/LO.
// Latency: 1 edge for single-cycle ops, WIDTH+1 edges for mult/multu/div/divu.
// Backpressure: busy=1 while a mult/div runs; any start seen during busy is dropped.
// Ports: clk, rst (sync, active-high); start, ctrl[3:0], A, B, shmnt;
//        result, zero (A==B at accept), busy, done (1-cycle pulse), hi, lo.
module mdu_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   shmnt,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic             accept;
    logic [WIDTH-1:0] res_sc;
    logic             done_q;
    logic             md_done;
    logic             md_fin;
    logic [WIDTH-1:0] md_fin_lo;

    assign accept = start & ~busy;

    always_comb begin
        res_sc = '0;
        case (ctrl)
            ALU_AND:  res_sc = A & B;
            ALU_OR:   res_sc = A | B;
            ALU_ADD:  res_sc = A + B;
            ALU_SUB:  res_sc = A - B;
            ALU_SLT:  res_sc = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU: res_sc = {{(WIDTH-1){1'b0}}, (A < B)};
            ALU_SLL:  res_sc = B << shmnt;
            ALU_SRL:  res_sc = B >> shmnt;
            ALU_SRA:  res_sc = $signed(B) >>> shmnt;
            ALU_NOR:  res_sc = ~(A | B);
            ALU_MFHI: res_sc = hi;
            ALU_MFLO: res_sc = lo;
            default:  ;  // mult/div results arrive through the iterative unit
        endcase
    end

    mul_div_unit #(.WIDTH(WIDTH)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (accept & is_muldiv(ctrl)),
        .op     (ctrl[1:0]),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (md_done),
        .fin    (md_fin),
        .fin_lo (md_fin_lo),
        .hi     (hi),
        .lo     (lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            zero   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // The new LO is mirrored into result on the same edge HI/LO are written.
            if (md_fin) begin
                result <= md_fin_lo;
            end
            if (accept) begin
                zero <= (A == B);
                if (!is_muldiv(ctrl)) begin
                    result <= res_sc;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done = done_q | md_done;

endmodule

// File: tb/tb_mdu_alu.sv
module tb_mdu_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   ctrl;
    logic [W-1:0] A, B;
    logic [4:0]   shmnt;
    logic [W-1:0] result, hi, lo;
    logic         zero, busy, done;

    mdu_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .ctrl(ctrl), .A(A), .B(B), .shmnt(shmnt),
        .result(result), .zero(zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   c;
        logic [W-1:0] res;
        logic         zero;
        logic         md;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    int           n_chk = 0;
    int           n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, expv);
        end
    endtask

    function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [4:0] s);
        exp_t              e;
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        up;
        e.c = c; e.zero = (a == b); e.md = is_muldiv(c); e.hi = m_hi; e.lo = m_lo; e.res = '0;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (c)
            ALU_AND:   e.res = a & b;
            ALU_OR:    e.res = a | b;
            ALU_ADD:   e.res = a + b;
            ALU_SUB:   e.res = a - b;
            ALU_SLT:   e.res = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU:  e.res = (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:   e.res = b << s;
            ALU_SRL:   e.res = b >> s;
            ALU_SRA:   e.res = (b >> s) | (b[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
            ALU_NOR:   e.res = ~(a | b);
            ALU_MFHI:  e.res = m_hi;
            ALU_MFLO:  e.res = m_lo;
            ALU_MULT:  begin sp = sa * sb; e.hi = sp[63:32]; e.lo = sp[31:0]; end
            ALU_MULTU: begin up = {32'd0, a} * {32'd0, b}; e.hi = up[63:32]; e.lo = up[31:0]; end
            ALU_DIV: begin
                if (b == 0) begin e.lo = '1; e.hi = a; end
                else begin sp = sa / sb; e.lo = sp[31:0]; sp = sa % sb; e.hi = sp[31:0]; end
            end
            default: begin
                if (b == 0) begin e.lo = '1; e.hi = a; end
                else begin e.lo = a / b; e.hi = a % b; end
            end
        endcase
        if (e.md) e.res = e.lo;
        return e;
    endfunction

    // Scoreboard: every done pulse consumes the oldest expected completion.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("result_c%0h", e.c), result, e.res);
                chk($sformatf("zero_c%0h", e.c), zero, e.zero);
                if (e.md) begin
                    chk($sformatf("hi_c%0h", e.c), hi, e.hi);
                    chk($sformatf("lo_c%0h", e.c), lo, e.lo);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] s);
        exp_t e;
        @(negedge clk);
        start = 1'b1; ctrl = c; A = a; B = b; shmnt = s;
        e = model(c, a, b, s);
        if (e.md) begin m_hi = e.hi; m_lo = e.lo; end
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for the done of a mult/div; optionally pokes a start while busy.
    task automatic wait_done(input int inject, input string tag);
        int edges = 0;
        int bcnt  = 0;
        bit seen  = 0;
        while (!seen && edges < 100) begin
            @(negedge clk);
            edges++;
            start = 1'b0;
            if (edges == inject) begin
                start = 1'b1; ctrl = ALU_ADD; A = 32'd1; B = 32'd2;
            end
            if (busy) bcnt++;
            if (done) seen = 1;
        end
        chk({tag, "_lat"}, edges, W + 1);
        chk({tag, "_busy"}, bcnt, W);
    endtask

    initial begin
        int ndone;
        rst = 1'b1; start = 1'b0; ctrl = '0; A = '0; B = '0; shmnt = '0;
        repeat (2) @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        rst = 1'b0;

        issue(ALU_ADD, 32'd5, 32'hFFFF_FFFD, 5'd0);
        idle();
        chk("add_done", done, 1);
        chk("add_result", result, 2);
        chk("add_zero", zero, 0);

        issue(ALU_SLT,  32'hFFFF_FFFF, 32'd1, 5'd0);
        issue(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0);
        issue(ALU_SRA,  32'd0, 32'h8000_0000, 5'd4);
        issue(ALU_SUB,  32'd7, 32'd7, 5'd0);
        issue(ALU_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0);
        issue(ALU_OR,   32'hF0F0_0000, 32'h0000_1234, 5'd0);
        issue(ALU_NOR,  32'hF0F0_0000, 32'h0000_1234, 5'd0);
        issue(ALU_SLL,  32'd0, 32'h0000_00F1, 5'd28);
        issue(ALU_SRL,  32'd0, 32'hF000_0000, 5'd31);
        issue(ALU_SRA,  32'd0, 32'h7000_0000, 5'd3);
        for (int i = 0; i < 8; i++)
            issue(4'($urandom_range(0, 11)), $urandom, $urandom, 5'($urandom_range(0, 31)));
        idle();

        issue(ALU_MULT, 32'hFFFF_FFFD, 32'd5, 5'd0);
        wait_done(0, "mult");
        issue(ALU_MFLO, 32'd0, 32'd0, 5'd0);
        issue(ALU_MFHI, 32'd0, 32'd0, 5'd0);
        idle();

        issue(ALU_DIV,  32'hFFFF_FFF9, 32'd2, 5'd0);              wait_done(0, "div");
        issue(ALU_DIVU, 32'd7, 32'd0, 5'd0);                       wait_done(0, "divu0");
        issue(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd0);       wait_done(0, "divmin");
        issue(ALU_DIV,  32'd7, 32'hFFFF_FFFE, 5'd0);               wait_done(0, "divneg");
        issue(ALU_DIV,  32'hFFFF_FFF7, 32'd0, 5'd0);               wait_done(0, "div0s");
        issue(ALU_MULT, 32'h8000_0000, 32'h8000_0000, 5'd0);       wait_done(0, "multmin");
        issue(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);      wait_done(0, "multu");
        for (int i = 0; i < 4; i++) begin
            issue(4'($urandom_range(12, 15)), $urandom, $urandom, 5'd0);
            wait_done(0, "rand_md");
        end

        issue(ALU_MULT, 32'd12345, 32'hFFFF_FD4A, 5'd0);
        wait_done(5, "mult_ign");
        issue(ALU_MFHI, 32'd0, 32'd0, 5'd0);
        idle();

        // Reset in the middle of a divide aborts it.
        issue(ALU_DIV, 32'd100, 32'd7, 5'd0);
        repeat (10) begin @(negedge clk); start = 1'b0; end
        rst = 1'b1;
        exp_q.delete();
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        rst = 1'b0;
        ndone = 0;
        repeat (40) begin @(negedge clk); if (done) ndone++; end
        chk("abort_nodone", ndone, 0);

        issue(ALU_DIVU, 32'd100, 32'd7, 5'd0);
        wait_done(0, "post_rst");
        issue(ALU_MFHI, 32'd0, 32'd0, 5'd0);
        idle();

        repeat (3) @(negedge clk);
        chk("q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
